// File: rtl/video_stream_source_if.sv
// Purpose: gray video stream bundle (upstream valid/ready pixels in, raster video out).
// Latency: n/a (wiring only).
// Backpressure: upstream side is valid/ready; the video side is free-running and never stalls.
interface video_stream_source_if #(
    parameter int DATA_WIDTH = 8
);
    // upstream pixel source
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    // raster video stream towards the filter chain
    logic                  post_frame_vsync;
    logic                  post_frame_href;
    logic                  post_frame_clken;
    logic [DATA_WIDTH-1:0] post_img_gray;

    // status
    logic                  frame_done;
    logic                  underflow;

    // the frame transmitter
    modport master (
        input  s_valid,
        input  s_data,
        output s_ready,
        output post_frame_vsync,
        output post_frame_href,
        output post_frame_clken,
        output post_img_gray,
        output frame_done,
        output underflow
    );

    // the pixel supplier / stream consumer around it
    modport slave (
        output s_valid,
        output s_data,
        input  s_ready,
        input  post_frame_vsync,
        input  post_frame_href,
        input  post_frame_clken,
        input  post_img_gray,
        input  frame_done,
        input  underflow
    );
endinterface

// File: rtl/video_stream_source.sv
// Purpose: emits frames of gray video with programmable raster timing, pulling pixels from a valid/ready source.
// Latency: 1 cycle from pixel slot (s_valid & s_ready) to post_img_gray/clken; all outputs registered.
// Backpressure: none downstream; a slot with s_valid low is still consumed, outputs 0 and sets sticky underflow.
module video_stream_source #(
    parameter int DATA_WIDTH = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_BLANK    = 160,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 2,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    video_stream_source_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    // one extra code so the last region boundary (== V_TOTAL when V_FRONT is 0) stays representable
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VB_START = VW'(V_SYNC);
    localparam logic [VW-1:0] VA_START = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] VF_START = VW'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    state_t          state;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            slot;
    logic            line_end;
    logic            frame_end;

    // Region a given frame line belongs to; zero-length regions fall through naturally.
    function automatic state_t line_state(input logic [VW-1:0] line);
        state_t st;
        if (line < VB_START) begin
            st = VSYNC;
        end else if (line < VA_START) begin
            st = VBACK;
        end else if (line < VF_START) begin
            st = ACTIVE;
        end else begin
            st = VFRONT;
        end
        return st;
    endfunction

    assign slot        = (state == ACTIVE) && (h_cnt < H_ACT);
    assign line_end    = (h_cnt == H_LAST);
    assign frame_end   = (state != IDLE) && line_end && (v_cnt == V_LAST);
    assign vif.s_ready = slot;

    // Raster FSM plus registered video outputs; enable only matters at frame boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            h_cnt                <= '0;
            v_cnt                <= '0;
            vif.post_frame_vsync <= 1'b0;
            vif.post_frame_href  <= 1'b0;
            vif.post_frame_clken <= 1'b0;
            vif.post_img_gray    <= '0;
            vif.frame_done       <= 1'b0;
            vif.underflow        <= 1'b0;
        end else begin
            vif.post_frame_vsync <= (state == VSYNC);
            vif.post_frame_href  <= slot;
            vif.post_frame_clken <= slot;
            vif.post_img_gray    <= (slot && vif.s_valid) ? vif.s_data : '0;
            vif.frame_done       <= frame_end;
            if (slot && !vif.s_valid) begin
                vif.underflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    h_cnt <= '0;
                    v_cnt <= '0;
                    if (enable) begin
                        state <= line_state('0);
                    end
                end
                default: begin
                    if (line_end) begin
                        h_cnt <= '0;
                        if (v_cnt == V_LAST) begin
                            v_cnt <= '0;
                            state <= enable ? line_state('0) : IDLE;
                        end else begin
                            v_cnt <= v_cnt + VW'(1);
                            state <= line_state(v_cnt + VW'(1));
                        end
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_video_stream_source.sv
// Purpose: scoreboard bench for video_stream_source on a 4x3 raster (H_BLANK=1, V_SYNC=1, V_BACK=0, V_FRONT=1).
// Latency: expected outputs for each cycle are queued by the driver and checked at the falling edge.
// Backpressure: exercises underflow slots, idle offers, back-to-back frames, late enable drop and mid-frame reset.
module tb_video_stream_source;
    localparam int FRAME = 25;  // 5 lines x 5 cycles

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic       clken;
        logic [7:0] gray;
        logic       fd;
        logic       uf;
        logic       rdy;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    video_stream_source_if #(.DATA_WIDTH(8)) vif ();

    video_stream_source #(
        .DATA_WIDTH(8),
        .H_ACTIVE  (4),
        .H_BLANK   (1),
        .V_SYNC    (1),
        .V_BACK    (0),
        .V_ACTIVE  (3),
        .V_FRONT   (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .vif   (vif)
    );

    always #5 clk = ~clk;

    // Hand-derived per-frame masks, bit k = state cycle k of the frame.
    // Line 0 is sync; lines 1..3 carry pixels in columns 0..3; line 4 is front porch.
    logic [24:0] vs_mask   = 25'h000001F;
    logic [24:0] slot_mask = 25'h0078000 | 25'h0003C00 | 25'h00001E0;

    out_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // driver-side expectation state
    int         cur_pos   = -1;  // frame position of the current cycle, -1 when idle
    logic       prev_vs   = 1'b0;
    logic       prev_slot = 1'b0;
    logic [7:0] prev_gray = 8'h00;
    logic       prev_fd   = 1'b0;
    logic       uf_m      = 1'b0;
    logic [7:0] data_cnt  = 8'h10;

    function automatic logic bit_at(input logic [24:0] m, input int p);
        return (p >= 0 && p < FRAME) ? m[p] : 1'b0;
    endfunction

    // One clock of stimulus; queues what the outputs must show during this cycle.
    task automatic step(input logic r, input logic en, input logic v);
        out_t e;
        logic cur_slot;
        rst          = r;
        enable       = en;
        vif.s_valid  = v;
        vif.s_data   = data_cnt;
        cur_slot     = bit_at(slot_mask, cur_pos);
        e.vsync      = prev_vs;
        e.href       = prev_slot;
        e.clken      = prev_slot;
        e.gray       = prev_gray;
        e.fd         = prev_fd;
        e.uf         = uf_m;
        e.rdy        = cur_slot;
        exp_q.push_back(e);
        if (r) begin
            prev_vs   = 1'b0;
            prev_slot = 1'b0;
            prev_gray = 8'h00;
            prev_fd   = 1'b0;
            uf_m      = 1'b0;
            cur_pos   = -1;
        end else begin
            prev_vs   = bit_at(vs_mask, cur_pos);
            prev_slot = cur_slot;
            prev_gray = (cur_slot && v) ? data_cnt : 8'h00;
            prev_fd   = (cur_pos == FRAME - 1);
            if (cur_slot && !v) uf_m = 1'b1;
            if (cur_slot && v) data_cnt = data_cnt + 8'd1;
            if (cur_pos == -1 || cur_pos == FRAME - 1) cur_pos = en ? 0 : -1;
            else cur_pos = cur_pos + 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per cycle and compares the full output picture.
    always @(negedge clk) begin
        out_t e;
        out_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.vsync = vif.post_frame_vsync;
            a.href  = vif.post_frame_href;
            a.clken = vif.post_frame_clken;
            a.gray  = vif.post_img_gray;
            a.fd    = vif.frame_done;
            a.uf    = vif.underflow;
            a.rdy   = vif.s_ready;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle_vec %0d: got vs=%b href=%b clken=%b gray=%h fd=%b uf=%b rdy=%b, want vs=%b href=%b clken=%b gray=%h fd=%b uf=%b rdy=%b",
                         vectors, a.vsync, a.href, a.clken, a.gray, a.fd, a.uf, a.rdy,
                         e.vsync, e.href, e.clken, e.gray, e.fd, e.uf, e.rdy);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        vif.s_valid = 1'b0;
        vif.s_data  = 8'h00;
        @(posedge clk);
        #1;

        // reset held, then idle with data offered but no slot open
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b1);

        // start, then three back-to-back frames
        step(1'b0, 1'b1, 1'b1);
        repeat (FRAME) step(1'b0, 1'b1, 1'b1);
        // frame 2: two starved slots at line 2 pixels 0 and 1
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, 1'b1, !(cur_pos == 10 || cur_pos == 11));
        end
        // frame 3: enable dropped mid-frame, frame still completes
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, (k < 12), 1'b1);
        end
        repeat (8) step(1'b0, 1'b0, 1'b1);

        // frame 4 aborted by a one-cycle reset at line 2 pixel 2, then a fresh frame
        step(1'b0, 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (FRAME + 2) step(1'b0, 1'b1, 1'b1);
        repeat (FRAME) step(1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/video_stream_source.md
Name: video_stream_source

Overview:
- Frame transmitter for the gray video stream protocol (vsync / href / clken / 8-bit gray) that all pipeline filters consume.
- Pulls pixels from an upstream valid/ready source, such as a frame-buffer reader or test-pattern ROM.
- Emits them with programmable raster timing and feeds the head of the filter chain (e.g. the Gaussian stage).
- Also serves as the stimulus driver in block-level benches.

Parameters:
- DATA_WIDTH, 8, pixel width.
- H_ACTIVE, 640, active pixels per line.
- H_BLANK, 160, blank cycles after each line (must be ≥1).
- V_SYNC, 2, lines with vsync high at frame start.
- V_BACK, 2, blank lines after sync, before first active line.
- V_ACTIVE, 480, active lines per frame.
- V_FRONT, 2, blank lines after last active line.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, run frames while high; sampled only at frame boundaries.
- s_valid, in, 1, upstream pixel valid.
- s_data, in, DATA_WIDTH, upstream pixel.
- s_ready, out, 1, pixel slot open (combinational from state/counters).
- post_frame_vsync, out, 1, frame sync.
- post_frame_href, out, 1, active line.
- post_frame_clken, out, 1, pixel strobe.
- post_img_gray, out, DATA_WIDTH, pixel value.
- frame_done, out, 1, one-cycle pulse at end of each frame.
- underflow, out, 1, sticky: a pixel slot had s_valid low.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: every output register is 0 (vsync, href, clken, gray, frame_done, underflow). State goes to IDLE and counters clear. s_ready is 0 in IDLE. A reset mid-frame aborts the frame immediately; no partial line is completed.
- Line timing:
  - Every line is H_ACTIVE + H_BLANK cycles.
  - h_cnt runs 0 .. H_ACTIVE+H_BLANK-1 and wraps.
  - v_cnt increments on wrap.
- States:
  - IDLE: if enable=1, go to VSYNC next cycle with h_cnt=v_cnt=0.
  - VSYNC: V_SYNC lines; post_frame_vsync=1 for every cycle of these lines.
  - VBACK: V_BACK lines, all outputs low. If V_BACK=0 this state is skipped.
  - ACTIVE: V_ACTIVE lines.
  - VFRONT: V_FRONT lines. On the last cycle, frame_done is pulsed (registered, visible the next cycle).
    - enable=1: go to VSYNC (back-to-back frames, no gap).
    - enable=0: go to IDLE.
- Dropping enable mid-frame has no effect until the frame ends.
- Pixel slot: in ACTIVE with h_cnt < H_ACTIVE, s_ready=1; elsewhere s_ready=0.
- Output timing (one-cycle latency, all registered): for slot cycle t, at t+1:
  - post_frame_href=1 and post_frame_clken=1.
  - post_img_gray = s_data if s_valid, else 0.
- Underflow: a slot with s_valid=0 still consumes the slot, outputs 0 and sets underflow. Stream timing never stalls. underflow clears only on rst.
- Outside slots: href=clken=0 and post_img_gray=0.
- Handshake: a pixel transfers only when s_valid & s_ready. Data offered outside slots is not consumed.
- Relation of signals:
  - href and clken are identical in this block (one pixel per clock).
  - vsync is never high while href is high.
- Frame length: (V_SYNC+V_BACK+V_ACTIVE+V_FRONT) × (H_ACTIVE+H_BLANK) cycles.
- Counter widths: sized by $clog2 of the line length and the total line count.

Test Plan:
- Reset and start: assert rst 3 cycles, release, hold enable=0 for 10 cycles → all outputs 0, s_ready=0. Raise enable at cycle T → post_frame_vsync=1 from T+2 for 2×800 cycles.
- Full frame at defaults, s_valid tied 1, s_data = incrementing counter:
  - 480 href pulses, each exactly 640 clken cycles, 160 low cycles between lines.
  - post_img_gray equals the accepted s_data one cycle later.
  - 307200 pixels total; frame_done pulses once, at cycle 486×800 after frame start.
  - underflow=0.
- Underflow: drop s_valid for 5 cycles in line 3 → 5 zero pixels on post_img_gray, line still 640 clken long, underflow=1 and stays 1 through the next frame.
- Back-to-back: enable held high for 2 frames → the second vsync rises the cycle after the first frame_done slot, with no IDLE gap. Deassert enable mid-frame 2 → frame 2 completes fully, then outputs stay 0.
- Mid-frame reset: assert rst for 1 cycle during line 100 pixel 300 → next cycle all outputs 0, s_ready=0. After release with enable=1, a fresh frame begins with vsync.
- Small geometry (H_ACTIVE=4, H_BLANK=1, V_SYNC=1, V_BACK=0, V_ACTIVE=3, V_FRONT=1): check the exact cycle waveform, including VBACK skipped and 12 pixels per frame.
